// File: rtl/phase_countdown.sv
// One-second prescaler shared by two independent countdown channels
// (pedestrian / vehicle phase). All outputs are registered.
module phase_countdown_ch #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [CW-1:0] cnt_i,
  output logic [CW-1:0] remain_o,
  output logic          end_o
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          end_q, end_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      end_q    <= end_d;
    end
  end

  // Load always wins over a coincident tick; ticks only matter in RUN.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    end_d    = end_q;
    if (load_i) begin
      remain_d = cnt_i;
      end_d    = (cnt_i == '0);
      state_d  = (cnt_i == '0) ? EXPIRED : RUN;
    end else if (tick_i) begin
      unique case (state_q)
        RUN: begin
          remain_d = remain_q - 1'b1;
          if (remain_q == CW'(1)) begin
            end_d   = 1'b1;
            state_d = EXPIRED;
          end
        end
        default: ;
      endcase
    end
  end

  assign remain_o = remain_q;
  assign end_o    = end_q;
endmodule

module phase_countdown #(
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_pulse_1s,
  input  logic          load_pd,
  input  logic [CW-1:0] cnt_pd,
  input  logic          load_nopd,
  input  logic [CW-1:0] cnt_nopd,
  output logic          sec_tick,
  output logic [CW-1:0] remain_pd,
  output logic [CW-1:0] remain_nopd,
  output logic          cnt_pd_end,
  output logic          cnt_nopd_end
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int NCH = 2;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Held at zero while disabled so the first tick lands TICK_DIV cycles after enable.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (enable_pulse_1s) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  logic [NCH-1:0]         ld;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0][CW-1:0] rem;
  logic [NCH-1:0]         ended;

  assign ld  = {load_nopd, load_pd};
  assign cnt = {cnt_nopd, cnt_pd};

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      phase_countdown_ch #(.CW(CW)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (tick_q),
        .load_i   (ld[g]),
        .cnt_i    (cnt[g]),
        .remain_o (rem[g]),
        .end_o    (ended[g])
      );
    end
  endgenerate

  assign sec_tick     = tick_q;
  assign remain_pd    = rem[0];
  assign remain_nopd  = rem[1];
  assign cnt_pd_end   = ended[0];
  assign cnt_nopd_end = ended[1];
endmodule

// File: tb/tb_phase_countdown.sv
// Directed bench for phase_countdown with TICK_DIV=4; expected values hand-computed.
module tb_phase_countdown;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load_pd, load_nopd;
  logic [3:0] cnt_pd, cnt_nopd;
  logic       sec_tick;
  logic [3:0] remain_pd, remain_nopd;
  logic       pd_end, nopd_end;

  int n_chk  = 0;
  int n_fail = 0;
  int ticks;

  phase_countdown #(.TICK_DIV(4), .CW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_pulse_1s (en),
    .load_pd         (load_pd),
    .cnt_pd          (cnt_pd),
    .load_nopd       (load_nopd),
    .cnt_nopd        (cnt_nopd),
    .sec_tick        (sec_tick),
    .remain_pd       (remain_pd),
    .remain_nopd     (remain_nopd),
    .cnt_pd_end      (pd_end),
    .cnt_nopd_end    (nopd_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    load_pd = 1'b0; load_nopd = 1'b0; cnt_pd = '0; cnt_nopd = '0;
    step(3);
    check("rst_tick", sec_tick, 0);
    check("rst_rpd", remain_pd, 0);
    check("rst_rnopd", remain_nopd, 0);
    check("rst_endpd", pd_end, 0);
    check("rst_endnopd", nopd_end, 0);

    // Tick cadence: visible after edges 4, 8, 12 counted from enable.
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("tick_e%0d", k), sec_tick, (k % 4 == 0) ? 1 : 0);
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("tick_off", sec_tick, 0);
    end
    check("idle_rpd", remain_pd, 0);
    check("idle_endpd", pd_end, 0);

    // pd=3 countdown; decrements on edges 5, 9, 13 after load.
    load_pd = 1'b1; cnt_pd = 4'd3; en = 1'b1;
    step(1);
    load_pd = 1'b0;
    check("pd3_load", remain_pd, 3);
    check("pd3_end0", pd_end, 0);
    step(4);  check("pd3_r2", remain_pd, 2);
    step(4);  check("pd3_r1", remain_pd, 1);
    check("pd3_end_lo", pd_end, 0);
    step(4);  check("pd3_r0", remain_pd, 0);
    check("pd3_end_hi", pd_end, 1);
    step(40);
    check("pd3_hold_r", remain_pd, 0);
    check("pd3_hold_end", pd_end, 1);

    // Load coincident with sec_tick: load wins.
    step(3);
    check("coinc_tick", sec_tick, 1);
    load_pd = 1'b1; cnt_pd = 4'd5;
    step(1);
    load_pd = 1'b0;
    check("coinc_r5", remain_pd, 5);
    check("coinc_end", pd_end, 0);
    step(3);  check("coinc_r5b", remain_pd, 5);
    step(1);  check("coinc_r4", remain_pd, 4);
    load_pd = 1'b1; cnt_pd = 4'd0;
    step(1);
    load_pd = 1'b0;
    check("zero_end", pd_end, 1);
    check("zero_r", remain_pd, 0);

    // nopd 8, expire, reload with 2.
    load_nopd = 1'b1; cnt_nopd = 4'd8;
    step(1);
    load_nopd = 1'b0;
    check("n8_load", remain_nopd, 8);
    step(29); check("n8_r1", remain_nopd, 1);
    check("n8_end_lo", nopd_end, 0);
    step(1);  check("n8_r0", remain_nopd, 0);
    check("n8_end_hi", nopd_end, 1);
    load_nopd = 1'b1; cnt_nopd = 4'd2;
    step(1);
    load_nopd = 1'b0;
    check("n2_load", remain_nopd, 2);
    check("n2_endclr", nopd_end, 0);
    step(3);  check("n2_r1", remain_nopd, 1);
    step(4);  check("n2_r0", remain_nopd, 0);
    check("n2_end", nopd_end, 1);

    // Simultaneous loads pd=8, nopd=10.
    load_pd = 1'b1; cnt_pd = 4'd8; load_nopd = 1'b1; cnt_nopd = 4'd10;
    step(1);
    load_pd = 1'b0; load_nopd = 1'b0;
    check("both_pd", remain_pd, 8);
    check("both_nopd", remain_nopd, 10);
    step(31);
    check("both_pd_end", pd_end, 1);
    check("both_pd_r", remain_pd, 0);
    check("both_nopd_r2", remain_nopd, 2);
    check("both_nopd_lo", nopd_end, 0);
    step(8);
    check("both_nopd_r0", remain_nopd, 0);
    check("both_nopd_end", nopd_end, 1);

    // Reset mid-count, coincident with a load.
    load_pd = 1'b1; cnt_pd = 4'd6;
    step(1);
    load_pd = 1'b0;
    step(7);  check("rstmid_r4", remain_pd, 4);
    rst = 1'b1; load_pd = 1'b1; cnt_pd = 4'd9;
    step(1);
    rst = 1'b0; load_pd = 1'b0;
    check("rstmid_tick", sec_tick, 0);
    check("rstmid_rpd", remain_pd, 0);
    check("rstmid_rnopd", remain_nopd, 0);
    check("rstmid_endpd", pd_end, 0);
    check("rstmid_endnopd", nopd_end, 0);
    ticks = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (sec_tick) ticks++;
    end
    check("post_rst_ticks", ticks, 7);
    check("post_rst_rpd", remain_pd, 0);
    check("post_rst_endpd", pd_end, 0);
    check("post_rst_endnopd", nopd_end, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
